// File: rtl/busmatrix_input_stage_hold.sv
// busmatrix_input_stage_hold: per-master AHB address-phase hold stage feeding an output-port arbiter.
// Optional BUSMATRIX_IN_ERR_CANCEL_EN turns a SEQ sampled in the second ERROR cycle into IDLE.
module busmatrix_input_stage_hold #(
  parameter int ADDR_W = 32,
  parameter int ERR_W  = 1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  input  logic              active_trans,
  input  logic              HREADYM,
  input  logic              data_phase_m,
  input  logic              HREADYOUTM,
  input  logic [ERR_W-1:0]  HRESPM,
  output logic              req_port,
  output logic [ADDR_W-1:0] HADDR_o,
  output logic [1:0]        HTRANS_o,
  output logic              HWRITE_o,
  output logic [2:0]        HSIZE_o,
  output logic [2:0]        HBURST_o,
  output logic [3:0]        HPROT_o,
  output logic              HMASTLOCK_o,
  output logic              HREADYOUTS,
  output logic [ERR_W-1:0]  HRESPS
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
  state_t state, state_nxt;
  logic pend, sample, accept, cancel, load, live;
  logic [ADDR_W-1:0] haddr_h;
  logic [1:0] htrans_h;
  logic hwrite_h, hmastlock_h;
  logic [2:0] hsize_h, hburst_h;
  logic [3:0] hprot_h;
  assign sample = HSELS & HREADYS & HTRANSS[1];
  assign accept = active_trans & HREADYM;
`ifdef BUSMATRIX_IN_ERR_CANCEL_EN
  assign cancel = (state == S_ERR2) & sample & (HTRANSS == 2'b11);
`else
  assign cancel = 1'b0;
`endif
  assign load = sample & ~accept & ~pend & ~cancel;
  // Live path is suppressed during reset so the arbiter sees the request drop at once.
  assign live = HSELS & ~HRESET & ~cancel;
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state       <= S_IDLE;
      pend        <= 1'b0;
      haddr_h     <= '0;
      htrans_h    <= '0;
      hwrite_h    <= 1'b0;
      hsize_h     <= '0;
      hburst_h    <= '0;
      hprot_h     <= '0;
      hmastlock_h <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        pend        <= 1'b1;
        haddr_h     <= HADDRS;
        htrans_h    <= HTRANSS;
        hwrite_h    <= HWRITES;
        hsize_h     <= HSIZES;
        hburst_h    <= HBURSTS;
        hprot_h     <= HPROTS;
        hmastlock_h <= HMASTLOCKS;
      end else if (pend & accept) begin
        pend <= 1'b0;
      end
    end
  end
  assign HADDR_o     = pend ? haddr_h : HADDRS;
  assign HTRANS_o    = pend ? htrans_h : (live ? HTRANSS : 2'b00);
  assign HWRITE_o    = pend ? hwrite_h : HWRITES;
  assign HSIZE_o     = pend ? hsize_h : HSIZES;
  assign HBURST_o    = pend ? hburst_h : HBURSTS;
  assign HPROT_o     = pend ? hprot_h : HPROTS;
  assign HMASTLOCK_o = pend ? hmastlock_h : HMASTLOCKS;
  assign req_port    = pend | (live & (HTRANSS[1] | HMASTLOCK_o));
  logic data_done;
  state_t start;
  assign data_done = data_phase_m & HREADYOUTM;
  assign start = cancel ? S_IDLE : (sample ? (accept ? S_DATA : S_WAIT) : S_IDLE);
  always_comb begin
    state_nxt  = state;
    HREADYOUTS = 1'b1;
    HRESPS     = '0;
    case (state)
      S_IDLE: state_nxt = start;
      S_WAIT: begin
        HREADYOUTS = 1'b0;
        state_nxt  = accept ? S_DATA : S_WAIT;
      end
      S_DATA: begin
        HREADYOUTS = data_done;
        state_nxt  = data_done ? start : ((data_phase_m & HRESPM[0]) ? S_ERR1 : S_DATA);
      end
      S_ERR1: begin
        HREADYOUTS = 1'b0;
        HRESPS     = ERR_W'(1);
        state_nxt  = S_ERR2;
      end
      S_ERR2: begin
        HRESPS    = ERR_W'(1);
        state_nxt = start;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: doc/busmatrix_input_stage_hold.md
Name: busmatrix_input_stage_hold

Overview:
- Per-master input stage of the sparse AHB bus matrix, directly upstream of each output-port arbiter.
- Captures the master's address phase whenever the target output port cannot take it in the same cycle, and holds it until the arbiter grants this port.
- Drives the held or live address phase and the request line to the arbiter.
- Drives the master's HREADYOUT/HRESP: stalls the master while a transfer is held, forwards the slave response once the transfer reaches its data phase.

Parameters:
ADDR_W, 32, address width of HADDRS/HADDR_o
ERR_W, 1, width of HRESPS (AHB-Lite, 1 = ERROR)

Ports:
HCLK  in  1  AHB system clock
HRESET  in  1  asynchronous active-high reset
HSELS  in  1  master select for this port
HADDRS  in  ADDR_W  master address
HTRANSS  in  2  master transfer type
HWRITES  in  1  master write
HSIZES  in  3  master size
HBURSTS  in  3  master burst type
HPROTS  in  4  master protection
HMASTLOCKS  in  1  master lock
HREADYS  in  1  bus-level HREADY seen by master
active_trans  in  1  arbiter has selected this port; output stage presents HADDR_o this cycle
HREADYM  in  1  output-side HREADY (slave ready)
data_phase_m  in  1  this port's transfer is in data phase at the output stage
HREADYOUTM  in  1  slave HREADYOUT routed back for this port
HRESPM  in  ERR_W  slave response routed back for this port
req_port  out  1  request to arbiter (valid NONSEQ/SEQ pending or live)
HADDR_o  out  ADDR_W  selected address (held when pend=1, else live)
HTRANS_o  out  2  selected transfer type
HWRITE_o, HSIZE_o, HBURST_o, HPROT_o, HMASTLOCK_o  out  1/3/3/4/1  selected controls
HREADYOUTS  out  1  ready to master
HRESPS  out  ERR_W  response to master

Behaviour:
- Reset (async, HRESET=1): pend=0, all hold registers 0, state=IDLE; outputs req_port=0, HTRANS_o=IDLE(00), HREADYOUTS=1, HRESPS=0.
- sample = HSELS & HREADYS & HTRANSS[1]. accept = active_trans & HREADYM.
- Hold register loads all address-phase signals on sample & ~accept. Sets pend=1 next cycle. Load only occurs when pend=0, guaranteed because HREADYOUTS=0 while pend=1.
- pend clears on accept while pend=1. Zero-latency path: sample & accept in the same cycle passes live signals through and leaves pend=0.
- Output mux: pend ? hold regs : live inputs. Live HTRANS_o is forced to IDLE when HSELS=0.
- req_port = pend | (HSELS & HTRANSS[1]). Also held high while HMASTLOCK_o=1 and HSELS=1, so the arbiter keeps the lock.
- Master response FSM, states IDLE, WAIT, DATA, ERR1, ERR2:
  - IDLE: HREADYOUTS=1, HRESPS=0. On sample: go to DATA if accept, else WAIT.
  - WAIT: HREADYOUTS=0, HRESPS=0. On accept go to DATA.
  - DATA: HREADYOUTS=HREADYOUTM only while data_phase_m=1, else 0.
    - HRESPM=1 & HREADYOUTM=0: go to ERR1.
    - HREADYOUTM=1: go to IDLE, or to WAIT/DATA if a new sample occurs the same cycle (pipelined back-to-back).
  - ERR1: HREADYOUTS=0, HRESPS=1. Then ERR2.
  - ERR2: HREADYOUTS=1, HRESPS=1. Then IDLE, applying the sample/accept rule.
- BUSY/IDLE from the master are never held and never request. IDLE during WAIT cannot occur because the master is stalled.
- Reset mid-operation drops any held transfer without a response; the arbiter sees req_port fall immediately.

Optional Feature:
BUSMATRIX_IN_ERR_CANCEL_EN
- Defined: a SEQ transfer sampled during ERR2 is not held or forwarded. It is converted to IDLE (HTRANS_o=00, req_port=0) and the master receives a zero-wait OKAY, giving clean burst cancellation after ERROR.
- Undefined: a SEQ sampled in ERR2 is treated as any other transfer (held/forwarded normally).

Test Plan:
- Zero-wait pass-through: NONSEQ HADDRS=0x1000, active_trans=1, HREADYM=1 -> HADDR_o=0x1000 same cycle, pend stays 0, HREADYOUTS=1 every cycle.
- Hold: NONSEQ 0x2000 with active_trans=0 for 3 cycles, then 1 -> HREADYOUTS=0 for 3 cycles, HADDR_o=0x2000 from hold regs, req_port=1; pend clears on grant.
- Master change mid-hold: HADDRS changed to 0x3000 while pend=1 -> HADDR_o stays 0x2000.
- Slave wait states: DATA with HREADYOUTM=0 for 2 cycles, then 1 -> HREADYOUTS mirrors 0,0,1.
- ERROR: HRESPM=1 with HREADYOUTM=0, then 1 -> HRESPS=1 for 2 cycles, HREADYOUTS=0 then 1.
  - With BUSMATRIX_IN_ERR_CANCEL_EN, a following SEQ gets HTRANS_o=00 and req_port=0.
- Reset: assert HRESET while pend=1 -> req_port=0, HREADYOUTS=1, HTRANS_o=00 asynchronously, before the next HCLK edge.
